// File: rtl/shot_pkg.sv
// shot_pkg: shared definitions for the shot collision detector slice.
//   NUM_SHOTS_DEF    : default number of shot slots
//   HIT_COUNT_W_DEF  : default width of the enemy hit counter
//   collision_kind_t : per-slot collision classification for one cycle
//   fsm_state_t      : frame-tracking FSM states
package shot_pkg;

    localparam int unsigned NUM_SHOTS_DEF   = 3;
    localparam int unsigned HIT_COUNT_W_DEF = 8;

    typedef enum logic [1:0] {
        COLL_NONE,
        COLL_ENEMY,
        COLL_TOWER
    } collision_kind_t;

    typedef enum logic {
        ST_WAIT_FRAME,
        ST_ACTIVE
    } fsm_state_t;

endpackage

// File: rtl/shot_hit_latch.sv
// shot_hit_latch: one shot slot's collision classifier.
// Holds a sticky "reported" flag so a slot pulses at most once per frame,
// gives enemy overlaps priority over tower overlaps, and registers the
// resulting one-cycle pulse.
// Ports:
//   clk           : clock
//   i_reset       : synchronous reset, active-high
//   i_active      : frame FSM is in the active state
//   i_sof         : frame-start strobe (clears the reported flag)
//   i_shot        : this slot's shot pixel request
//   i_enemy       : enemy pixel request
//   i_tower       : tower pixel request
//   o_enemy_pulse : registered enemy-hit pulse
//   o_tower_pulse : registered tower-hit pulse
module shot_hit_latch
    import shot_pkg::*;
(
    input  logic clk,
    input  logic i_reset,
    input  logic i_active,
    input  logic i_sof,
    input  logic i_shot,
    input  logic i_enemy,
    input  logic i_tower,
    output logic o_enemy_pulse,
    output logic o_tower_pulse
);

    logic            r_reported;
    logic            r_enemy_pulse;
    logic            r_tower_pulse;
    logic            w_reported_eff;
    collision_kind_t w_kind;

    // The frame-start clear takes effect in the same cycle, so an overlap
    // coinciding with startOfFrame belongs to the new frame.
    always_comb begin
        w_reported_eff = r_reported & ~i_sof;
        w_kind         = COLL_NONE;
        if (i_active && i_shot && !w_reported_eff) begin
            if (i_enemy) begin
                w_kind = COLL_ENEMY;
            end else if (i_tower) begin
                w_kind = COLL_TOWER;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_reported    <= 1'b0;
            r_enemy_pulse <= 1'b0;
            r_tower_pulse <= 1'b0;
        end else begin
            r_reported    <= w_reported_eff | (w_kind != COLL_NONE);
            r_enemy_pulse <= (w_kind == COLL_ENEMY);
            r_tower_pulse <= (w_kind == COLL_TOWER);
        end
    end

    assign o_enemy_pulse = r_enemy_pulse;
    assign o_tower_pulse = r_tower_pulse;

endmodule

// File: rtl/shot_collision_detector.sv
// shot_collision_detector: per-slot shot/enemy and shot/tower collision
// pulses with a frame-start FSM and an optional saturating hit counter.
// Optional feature macro: SHOT_COLLISION_HITCOUNT_EN (builds hitCount;
// without it hitCount is tied to 0).
// Ports:
//   clk                 : clock
//   resetN              : synchronous reset, active-high
//   startOfFrame        : one-cycle frame-start strobe
//   shotDrawingRequests : per-slot shot pixel requests
//   enemyDrawingRequest : enemy pixel request
//   towerDrawingRequest : tower pixel request
//   shotEnemyCollision  : per-slot enemy-hit pulses (latency 1)
//   shotTowerCollision  : per-slot tower-hit pulses (latency 1)
//   enemyHit            : OR of shotEnemyCollision
//   hitCount            : saturating count of enemy hits
module shot_collision_detector
    import shot_pkg::*;
#(
    parameter int unsigned NUM_SHOTS   = NUM_SHOTS_DEF,
    parameter int unsigned HIT_COUNT_W = HIT_COUNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic [NUM_SHOTS-1:0]   shotDrawingRequests,
    input  logic                   enemyDrawingRequest,
    input  logic                   towerDrawingRequest,
    output logic [NUM_SHOTS-1:0]   shotEnemyCollision,
    output logic [NUM_SHOTS-1:0]   shotTowerCollision,
    output logic                   enemyHit,
    output logic [HIT_COUNT_W-1:0] hitCount
);

    fsm_state_t r_state;
    fsm_state_t w_next_state;
    logic       w_active;

    always_ff @(posedge clk) begin
        if (resetN) begin
            r_state <= ST_WAIT_FRAME;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_active     = 1'b0;
        case (r_state)
            ST_WAIT_FRAME: begin
                if (startOfFrame) begin
                    w_next_state = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                w_active = 1'b1;
            end
            default: begin
                w_next_state = ST_WAIT_FRAME;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_SHOTS; gi++) begin : g_slot
        shot_hit_latch u_latch (
            .clk           (clk),
            .i_reset       (resetN),
            .i_active      (w_active),
            .i_sof         (startOfFrame),
            .i_shot        (shotDrawingRequests[gi]),
            .i_enemy       (enemyDrawingRequest),
            .i_tower       (towerDrawingRequest),
            .o_enemy_pulse (shotEnemyCollision[gi]),
            .o_tower_pulse (shotTowerCollision[gi])
        );
    end

    assign enemyHit = |shotEnemyCollision;

`ifdef SHOT_COLLISION_HITCOUNT_EN
    logic [HIT_COUNT_W-1:0] r_hit_count;
    logic [HIT_COUNT_W:0]   w_sum;

    // One spare bit catches overflow; the visible pulses are added at the
    // edge that ends them.
    always_comb begin
        w_sum = {1'b0, r_hit_count};
        for (int unsigned i = 0; i < NUM_SHOTS; i++) begin
            w_sum = w_sum + {{HIT_COUNT_W{1'b0}}, shotEnemyCollision[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            r_hit_count <= '0;
        end else if (w_sum[HIT_COUNT_W]) begin
            r_hit_count <= '1;
        end else begin
            r_hit_count <= w_sum[HIT_COUNT_W-1:0];
        end
    end

    assign hitCount = r_hit_count;
`else
    assign hitCount = '0;
`endif

endmodule

// File: doc/shot_collision_detector.md
SHOT_COLLISION_DETECTOR -- requirements
Module: shot_collision_detector

Interface
REQ-001 The block SHALL have parameter NUM_SHOTS, default 3, giving the number of shot slots.
REQ-002 The block SHALL have parameter HIT_COUNT_W, default 8, giving the hitCount width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port resetN, input, 1 bit: synchronous reset, active-high (asserted at 1).
REQ-005 The block SHALL have port startOfFrame, input, 1 bit: one-cycle frame-start strobe.
REQ-006 The block SHALL have port shotDrawingRequests, input, NUM_SHOTS bits: per-slot shot pixel request from the shot stock stage.
REQ-007 The block SHALL have port enemyDrawingRequest, input, 1 bit: enemy pixel request.
REQ-008 The block SHALL have port towerDrawingRequest, input, 1 bit: tower pixel request.
REQ-009 The block SHALL have port shotEnemyCollision, output, NUM_SHOTS bits: per-slot enemy-hit pulse.
REQ-010 The block SHALL have port shotTowerCollision, output, NUM_SHOTS bits: per-slot tower-hit pulse.
REQ-011 The block SHALL have port enemyHit, output, 1 bit: pulse when any slot hits an enemy.
REQ-012 The block SHALL have port hitCount, output, HIT_COUNT_W bits: saturating count of enemy hits.

Function
REQ-013 The block SHALL run a two-state FSM: WAIT_FRAME after reset, moving to ACTIVE on the first startOfFrame; ACTIVE is held until reset.
REQ-014 In WAIT_FRAME, all collision outputs and enemyHit SHALL be 0, and overlaps SHALL be ignored.
REQ-015 In ACTIVE, slot i SHALL see an enemy overlap when shotDrawingRequests[i] and enemyDrawingRequest are both 1 in the same cycle.
REQ-016 In ACTIVE, slot i SHALL see a tower overlap when shotDrawingRequests[i] and towerDrawingRequest are both 1 in the same cycle.
REQ-017 Each overlap SHALL produce a registered one-cycle pulse on the matching output in the next cycle (latency 1).
REQ-018 Each slot SHALL hold a sticky "reported" flag; once set, that slot SHALL emit no further pulses of either kind until the next startOfFrame.
REQ-019 If a slot sees an enemy overlap and a tower overlap in the same cycle, only shotEnemyCollision[i] SHALL pulse.
REQ-020 When startOfFrame is 1, all reported flags SHALL clear; an overlap in that same cycle SHALL count for the new frame and SHALL set the flag again.
REQ-021 Different slots SHALL be independent, so several bits may pulse in the same cycle.
REQ-022 enemyHit SHALL equal the OR of shotEnemyCollision, with the same timing.
REQ-023 hitCount SHALL add the popcount of shotEnemyCollision (0..NUM_SHOTS) on the cycle those pulses are high.
REQ-024 hitCount SHALL saturate at 2^HIT_COUNT_W-1 and SHALL never wrap.

Reset
REQ-025 While resetN=1 at a clk edge: FSM SHALL go to WAIT_FRAME, all flags SHALL clear, and all outputs SHALL be 0 (hitCount = 0).
REQ-026 A reset in the middle of a frame SHALL cancel any pending pulse; no pulse SHALL appear in the cycle after reset.

Configuration
REQ-027 With macro SHOT_COLLISION_HITCOUNT_EN defined, the hitCount counter SHALL be built as in REQ-023 and REQ-024.
REQ-028 Without SHOT_COLLISION_HITCOUNT_EN, hitCount SHALL be constant 0 and no counter logic SHALL be built; all other behaviour SHALL be unchanged.

Structure
REQ-029 Shared package shot_pkg SHALL hold the NUM_SHOTS default, the HIT_COUNT_W default, and enum collision_kind_t {COLL_NONE, COLL_ENEMY, COLL_TOWER}.
REQ-030 Per-slot flag, priority and pulse logic SHALL be one sub-module, shot_hit_latch, instantiated NUM_SHOTS times in a generate loop.
REQ-031 The FSM and hitCount SHALL live in the top module.

Verification
REQ-032 Bench SHALL check: overlap before first startOfFrame -> all outputs stay 0; FSM stays WAIT_FRAME.
REQ-033 Bench SHALL check: after startOfFrame, shotDrawingRequests=001 with enemy=1 for 5 cycles -> shotEnemyCollision=001 for exactly one cycle, 1 cycle after the first overlap; enemyHit=1 for that cycle; hitCount=1.
REQ-034 Bench SHALL check: shotDrawingRequests=010 with enemy=1 and tower=1 in the same cycle -> shotEnemyCollision=010 and shotTowerCollision=000.
REQ-035 Bench SHALL check: shotDrawingRequests=111 with enemy=1 in one cycle -> shotEnemyCollision=111 and hitCount +3; with hitCount preloaded to 254 -> hitCount=255 and stays 255.
REQ-036 Bench SHALL check: a slot hits in frame N, then overlaps again in frame N and in the startOfFrame cycle of N+1 -> exactly one pulse in frame N and one pulse in frame N+1.
REQ-037 Bench SHALL check: resetN=1 in the cycle an overlap occurs -> no pulse follows, hitCount=0, and FSM is WAIT_FRAME; repeat with the macro undefined -> hitCount stays 0 throughout.
